// File: rtl/mux_rr_n_pkg.sv
// Shared constants and FSM encoding for the N-way registered mux/arbiter.
package mux_rr_n_pkg;
  localparam int N_DEF = 4;
  localparam int W_DEF = 8;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } state_t;
endpackage

// File: rtl/mux_rr_n_rr_arbiter.sv
// Round-robin search: first asserted request at or above ptr, wrapping modulo N.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int SW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [SW-1:0] idx
);
  always_comb begin
    logic found;
    int   j;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = SW'(j);
      end
    end
  end
endmodule

// File: rtl/mux_rr_n.sv
// N-channel mux with one registered output beat, static or round-robin select.
// Optional packet locking (in_last/out_last, ARB/LOCK FSM) under MUX_RR_N_LOCK_EN.
module mux_rr_n
  import mux_rr_n_pkg::*;
#(
  parameter  int N  = N_DEF,
  parameter  int W  = W_DEF,
  localparam int SW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mode,
  input  logic [SW-1:0]   s,
  input  logic [N*W-1:0]  in_data,
  input  logic [N-1:0]    in_valid,
  output logic [N-1:0]    in_ready,
`ifdef MUX_RR_N_LOCK_EN
  input  logic [N-1:0]    in_last,
  output logic            out_last,
`endif
  output logic [W-1:0]    out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SW-1:0]   out_ch
);
  typedef struct packed {
    logic [W-1:0]  data;
    logic [SW-1:0] ch;
  } beat_t;

  localparam logic [SW:0] NCH = (SW+1)'(N);

  logic [N-1:0][W-1:0] din;
  logic [N-1:0]        rr_gnt, arb_gnt, gnt;
  logic [SW-1:0]       rr_idx, arb_idx, g, ptr;
  logic                ld, en, xfer, ptr_upd;
  beat_t               beat_q;

  assign din = in_data;
  assign ld  = !out_valid || out_ready;
  // Reset gating keeps in_ready low while rst_n is held, even though ld is high.
  assign en  = ld && rst_n;

  rr_arbiter #(.N(N), .SW(SW)) u_arb (
    .req (in_valid),
    .ptr (ptr),
    .gnt (rr_gnt),
    .idx (rr_idx)
  );

  always_comb begin
    arb_gnt = '0;
    arb_idx = '0;
    if (mode) begin
      arb_gnt = rr_gnt;
      arb_idx = rr_idx;
    end else if (({1'b0, s} < NCH) && in_valid[s]) begin
      arb_gnt[s] = 1'b1;
      arb_idx    = s;
    end
  end

`ifdef MUX_RR_N_LOCK_EN
  state_t        state, state_nxt;
  logic [SW-1:0] lock_ch, lock_nxt;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= ARB;
      lock_ch <= '0;
    end else begin
      state   <= state_nxt;
      lock_ch <= lock_nxt;
    end

  always_comb begin
    state_nxt = state;
    lock_nxt  = lock_ch;
    gnt       = arb_gnt;
    g         = arb_idx;
    xfer      = en && |arb_gnt;
    ptr_upd   = xfer && mode;
    case (state)
      ARB:
        if (xfer && !in_last[arb_idx]) begin
          state_nxt = LOCK;
          lock_nxt  = arb_idx;
          ptr_upd   = 1'b0;
        end
      LOCK: begin
        gnt          = '0;
        gnt[lock_ch] = in_valid[lock_ch];
        g            = lock_ch;
        xfer         = en && in_valid[lock_ch];
        ptr_upd      = xfer && in_last[lock_ch] && mode;
        if (xfer && in_last[lock_ch]) state_nxt = ARB;
      end
      default: state_nxt = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)    out_last <= 1'b0;
    else if (xfer) out_last <= in_last[g];
`else
  always_comb begin
    gnt     = arb_gnt;
    g       = arb_idx;
    xfer    = en && |arb_gnt;
    ptr_upd = xfer && mode;
  end
`endif

  assign in_ready = en ? gnt : '0;

  // A load takes priority over the pop, which gives one beat per cycle.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      beat_q    <= '0;
      ptr       <= '0;
    end else begin
      if (xfer) begin
        out_valid <= 1'b1;
        beat_q    <= '{data: din[g], ch: g};
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (ptr_upd) ptr <= (g == SW'(N-1)) ? '0 : g + 1'b1;
    end

  assign out_data = beat_q.data;
  assign out_ch   = beat_q.ch;
endmodule

// File: tb/tb_mux_rr_n.sv
// Directed bench for mux_rr_n: expected beats queued at issue, popped by a monitor.
module tb_mux_rr_n;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int SW = 2;

  logic            clk = 1'b0, rst_n = 1'b0, mode = 1'b0, out_ready = 1'b0;
  logic [SW-1:0]   s = '0;
  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_valid = '0, in_ready;
  logic [W-1:0]    out_data;
  logic            out_valid;
  logic [SW-1:0]   out_ch;
`ifdef MUX_RR_N_LOCK_EN
  logic [N-1:0]    in_last = '1;
  logic            out_last;
`endif

  typedef struct packed {
    logic [W-1:0]  data;
    logic [SW-1:0] ch;
    logic          last;
  } exp_t;

  exp_t q[$];
  int   checks = 0, failures = 0;

  always #5 clk = ~clk;

  assign in_data = {8'h3C, 8'hA5, 8'h21, 8'h10};

  mux_rr_n #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .s         (s),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
`ifdef MUX_RR_N_LOCK_EN
    .in_last   (in_last),
    .out_last  (out_last),
`endif
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch)
  );

  function automatic logic [W-1:0] dval(input int c);
    case (c)
      0:       return 8'h10;
      1:       return 8'h21;
      2:       return 8'hA5;
      default: return 8'h3C;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int ch, input logic last);
    q.push_back('{data: dval(ch), ch: SW'(ch), last: last});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: a beat is consumed on the edge following a negedge with valid && ready.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL beat_unexpected: got ch=%0d data=%0h, expected no beat", out_ch, out_data);
      end else begin
        e = q.pop_front();
        if (out_data !== e.data || out_ch !== e.ch
`ifdef MUX_RR_N_LOCK_EN
            || out_last !== e.last
`endif
           ) begin
          failures++;
          $display("FAIL beat: got ch=%0d data=%0h, expected ch=%0d data=%0h last=%0b",
                   out_ch, out_data, e.ch, e.data, e.last);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [N-1:0] eh;
    // Reset: outputs cleared and in_ready gated off even with all channels valid
    #12;
    in_valid = '1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data",  out_data,  0);
    chk("rst_out_ch",    out_ch,    0);
    chk("rst_in_ready",  in_ready,  0);
    in_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Static select of ch2 with ch0/ch2 valid
    out_ready = 1'b1; mode = 1'b0; s = 2'd2; in_valid = 4'b0101;
    #1;
    chk("static_in_ready", in_ready, 4'b0100);
    push(2, 1'b1);
    step();
    in_valid = '0;
    chk("static_out_valid", out_valid, 1);
    chk("static_out_data",  out_data,  8'hA5);
    chk("static_out_ch",    out_ch,    2);
    s = 2'd1; in_valid = 4'b0101;
    #1;
    chk("static_unselected", in_ready, 4'b0000);
    step();
    chk("idle_out_valid_clear", out_valid, 0);
    in_valid = '0;

    // Round robin with all valid: 0,1,2,3,0
    mode = 1'b1; in_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      eh = N'(1) << (k % 4);
      chk("rr_in_ready", in_ready, eh);
      push(k % 4, 1'b1);
      step();
    end
    in_valid = '0;
    step();

    // ptr currently 1: ch2 moves it to 3, then lone ch1 wraps, ptr becomes 2
    in_valid = 4'b0100;
    #1; chk("rr_ch2", in_ready, 4'b0100); push(2, 1'b1);
    step();
    in_valid = 4'b0010;
    #1; chk("rr_wrap_ch1", in_ready, 4'b0010); push(1, 1'b1);
    step();
    in_valid = 4'b1010;
    #1; chk("rr_ptr_is_2", in_ready, 4'b1000); push(3, 1'b1);
    step();
    in_valid = '0;
    step();

    // Backpressure: stall 3 cycles, then pop and load together
    out_ready = 1'b0; mode = 1'b0; s = 2'd0; in_valid = 4'b0001;
    #1; chk("bp_load", in_ready, 4'b0001); push(0, 1'b1);
    step();
    s = 2'd3; in_valid = 4'b1000;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_in_ready",  in_ready,  4'b0000);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_data",  out_data,  8'h10);
      chk("bp_out_ch",    out_ch,    0);
      step();
    end
    out_ready = 1'b1;
    #1; chk("bp_release_ready", in_ready, 4'b1000); push(3, 1'b1);
    step();
    in_valid = '0;
    chk("bp_new_valid", out_valid, 1);
    chk("bp_new_data",  out_data,  8'h3C);
    chk("bp_new_ch",    out_ch,    3);
    step();

    // Asynchronous reset while holding a beat; beat discarded, ptr back to 0
    out_ready = 1'b0; s = 2'd1; in_valid = 4'b0010;
    step();
    in_valid = '0;
    chk("pre_rst_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_data",  out_data,  0);
    chk("async_rst_ch",    out_ch,    0);
    in_valid = 4'b1010;
    #1; chk("async_rst_ready", in_ready, 4'b0000);
    rst_n = 1'b1; mode = 1'b1; out_ready = 1'b1;
    #1; chk("post_rst_grant", in_ready, 4'b0010); push(1, 1'b1);
    step();
    in_valid = '0;
    step();

`ifdef MUX_RR_N_LOCK_EN
    // ptr=2: ch2 sends 3 beats; lock must override mode/s while ch0/ch1 are valid
    in_valid = 4'b0111; in_last = 4'b1011;
    #1; chk("lock_beat1", in_ready, 4'b0100); push(2, 1'b0);
    step();
    mode = 1'b0; s = 2'd0;
    #1; chk("lock_beat2", in_ready, 4'b0100); push(2, 1'b0);
    step();
    mode = 1'b1; in_last = 4'b1111;
    #1; chk("lock_beat3", in_ready, 4'b0100); push(2, 1'b1);
    step();
    in_valid = 4'b1011;
    #1; chk("lock_after_ptr3", in_ready, 4'b1000); push(3, 1'b1);
    step();
    in_valid = '0;
    step();
`endif

    step();
    chk("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mux_rr_n.md
MUX_RR_N -- requirements
Module: mux_rr_n

Interface
REQ-001 SHALL have parameter N, default 4, number of input channels (N >= 2).
REQ-002 SHALL have parameter W, default 8, data width per channel.
REQ-003 SHALL derive localparam SW = $clog2(N), channel index width.
REQ-004 SHALL have port clk  input  1  single clock, all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port mode  input  1  0 = static select via s, 1 = round-robin.
REQ-007 SHALL have port s  input  SW  static channel select, used when mode=0.
REQ-008 SHALL have port in_data  input  N*W  channel i occupies bits [i*W +: W].
REQ-009 SHALL have ports in_valid (input) and in_ready (output), N bits each, per-channel handshake.
REQ-010 SHALL have ports out_data (output, W), out_valid (output, 1) and out_ready (input, 1).
REQ-011 SHALL have port out_ch  output  SW  index of the channel that supplied out_data.

Function
REQ-012 SHALL hold one registered output beat; load enable ld = !out_valid || out_ready.
REQ-013 SHALL grant at most one channel per cycle; in_ready[i] = ld && grant[i], with all other in_ready bits 0.
REQ-014 SHALL, with mode=0, grant channel s when in_valid[s]=1; s >= N grants nothing.
REQ-015 SHALL, with mode=1, grant the first channel with valid asserted, searching upward from ptr modulo N.
REQ-016 SHALL, on a transfer (in_valid[g] && in_ready[g]), register in_data[g] into out_data and g into out_ch, and set out_valid=1 on the next edge (latency 1 cycle).
REQ-017 SHALL clear out_valid when out_ready=1 and no transfer occurs; out_data and out_ch hold their values.
REQ-018 SHALL support simultaneous output pop and input load in the same cycle (full throughput, one beat per cycle).
REQ-019 SHALL, on each mode=1 transfer, update ptr to (g+1) mod N, wrapping from N-1 to 0; ptr SHALL NOT change in mode=0.
REQ-020 SHALL allow mode or s to change at any cycle, with effect from the next arbitration; a beat already registered is unaffected.
REQ-021 SHALL keep out_data, out_ch and out_valid stable while out_valid=1 and out_ready=0.

Reset
REQ-022 SHALL, while rst_n=0, force out_valid=0, out_data=0, out_ch=0, ptr=0, FSM=ARB, and all in_ready=0.
REQ-023 SHALL discard any beat held in the output register when reset asserts mid-operation; the first arbitration after release gives priority to channel 0.

Configuration
REQ-024 SHALL provide macro MUX_RR_N_LOCK_EN; when it is defined, ports in_last (input, N) and out_last (output, 1) SHALL exist.
REQ-025 SHALL, with MUX_RR_N_LOCK_EN, run FSM ARB/LOCK: ARB->LOCK on a transfer with in_last[g]=0; LOCK->ARB on a transfer from the locked channel with in_last=1.
REQ-026 SHALL, in LOCK, grant only the locked channel regardless of mode and s; out_last SHALL be registered alongside out_data; ptr SHALL update only on the LOCK->ARB transfer.
REQ-027 SHALL, without MUX_RR_N_LOCK_EN, omit in_last, out_last and the FSM, and arbitrate every beat independently.

Structure
REQ-028 SHALL place the FSM state enum (ARB, LOCK) and default N/W constants in shared package mux_rr_n_pkg.
REQ-029 SHALL instantiate sub-module rr_arbiter (N-bit request, SW-bit pointer in; one-hot grant and encoded index out) for the round-robin search.

Verification
REQ-030 SHALL cover: mode=0, s=2, in_valid=4'b0101, in_data ch2=8'hA5 -> in_ready=4'b0100, one cycle later out_valid=1, out_data=8'hA5, out_ch=2.
REQ-031 SHALL cover: mode=1, in_valid=4'b1111 held, out_ready=1 -> out_ch sequence 0,1,2,3,0 on consecutive cycles.
REQ-032 SHALL cover: out_ready=0 for 3 cycles with out_valid=1 -> all in_ready=0, output stable; then out_ready=1 -> pop and new load in the same cycle.
REQ-033 SHALL cover: mode=1, ptr=3, only in_valid[1]=1 -> grant ch1, after which ptr=2.
REQ-034 SHALL cover: rst_n pulled low while out_valid=1 -> out_valid=0 immediately (asynchronous); after release with in_valid=4'b1010 -> first grant ch1.
REQ-035 SHALL cover, with MUX_RR_N_LOCK_EN: ch2 sends a 3-beat packet (in_last on beat 3) while ch0/ch1 are valid -> three consecutive beats with out_ch=2, out_last on the third, then ch3 or wrap per ptr.
